// File: rtl/sobel_grad_pipe.sv
// 3x3 Sobel gradient pipeline: luma -> Gx/Gy -> selectable magnitude or edge bit, plus edge counter.
// Latency 3 cycles; all stages stall together when the output holds a beat the sink has not taken.
module sobel_grad_pipe #(
  parameter int CH_W    = 8,
  parameter int GRAY_IN = 0,
  parameter int USER_W  = 2,
  parameter int CNT_W   = 24,
  localparam int PIX_W  = 3*CH_W,
  localparam int LUM_W  = CH_W+4,
  localparam int G_W    = LUM_W+3,
  localparam int OUT_W  = 2*(LUM_W+2)+1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9*PIX_W-1:0] win_i,
  input  logic [USER_W-1:0]  user_i,
  input  logic [1:0]         mode_i,
  input  logic [G_W-1:0]     thresh_i,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   data_o,
  output logic [USER_W-1:0]  user_o,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clr_count_i,
  output logic [CNT_W-1:0]   edge_count_o
);

  localparam logic [1:0] MODE_SQ   = 2'd0;
  localparam logic [1:0] MODE_L1   = 2'd1;
  localparam logic [1:0] MODE_EDGE = 2'd2;

  function automatic logic [LUM_W-1:0] lum_of(input logic [PIX_W-1:0] pix);
    logic [LUM_W-1:0] r, g, b;
    r = {{(LUM_W-CH_W){1'b0}}, pix[3*CH_W-1 -: CH_W]};
    g = {{(LUM_W-CH_W){1'b0}}, pix[2*CH_W-1 -: CH_W]};
    b = {{(LUM_W-CH_W){1'b0}}, pix[CH_W-1:0]};
    if (GRAY_IN != 0)
      return {pix[CH_W-1:0], 4'b0000};
    else
      return (r << 2) + r + (g << 3) + g + (b << 1);
  endfunction

  function automatic logic [G_W-1:0] ext(input logic [LUM_W-1:0] y);
    return {{(G_W-LUM_W){1'b0}}, y};
  endfunction

  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // The centre pixel has zero weight in both kernels, so only eight lumas are kept:
  // slot j holds window position j for j<4 and position j+1 for j>=4.
  logic [LUM_W-1:0] lum_n [8];
  logic             centre_unused;
  assign centre_unused = ^win_i[4*PIX_W +: PIX_W];

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      lum_n[j] = lum_of(win_i[((j < 4) ? j : j+1)*PIX_W +: PIX_W]);
    end
  end

  logic              v1;
  logic [LUM_W-1:0]  y1 [8];
  logic [1:0]        m1;
  logic [G_W-1:0]    t1;
  logic [USER_W-1:0] u1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1 <= 1'b0;
      m1 <= '0;
      t1 <= '0;
      u1 <= '0;
      for (int j = 0; j < 8; j++) y1[j] <= '0;
    end else if (advance) begin
      v1 <= in_valid;
      m1 <= mode_i;
      t1 <= thresh_i;
      u1 <= user_i;
      for (int j = 0; j < 8; j++) y1[j] <= lum_n[j];
    end
  end

  // Gradients are held as two's complement bit patterns; the range fits G_W exactly.
  logic [G_W-1:0] gx_n, gy_n;
  assign gx_n = (ext(y1[2]) + (ext(y1[4]) << 1) + ext(y1[7]))
              - (ext(y1[0]) + (ext(y1[3]) << 1) + ext(y1[5]));
  assign gy_n = (ext(y1[5]) + (ext(y1[6]) << 1) + ext(y1[7]))
              - (ext(y1[0]) + (ext(y1[1]) << 1) + ext(y1[2]));

  logic              v2;
  logic [G_W-1:0]    gx2, gy2;
  logic [1:0]        m2;
  logic [G_W-1:0]    t2;
  logic [USER_W-1:0] u2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v2  <= 1'b0;
      gx2 <= '0;
      gy2 <= '0;
      m2  <= '0;
      t2  <= '0;
      u2  <= '0;
    end else if (advance) begin
      v2  <= v1;
      gx2 <= gx_n;
      gy2 <= gy_n;
      m2  <= m1;
      t2  <= t1;
      u2  <= u1;
    end
  end

  logic [G_W-1:0]   ax, ay, l1;
  logic [OUT_W-1:0] axw, ayw, sqx, sqy, res_n;

  always_comb begin
    ax  = gx2[G_W-1] ? -gx2 : gx2;
    ay  = gy2[G_W-1] ? -gy2 : gy2;
    l1  = ax + ay;
    axw = {{(OUT_W-G_W){1'b0}}, ax};
    ayw = {{(OUT_W-G_W){1'b0}}, ay};
    sqx = axw * axw;
    sqy = ayw * ayw;
    res_n = sqx;
    case (m2)
      MODE_SQ:   res_n = sqx + sqy;
      MODE_L1:   res_n = {{(OUT_W-G_W){1'b0}}, l1};
      MODE_EDGE: res_n = {{(OUT_W-1){1'b0}}, (l1 >= t2)};
      default:   res_n = sqx;
    endcase
  end

  logic [1:0] m3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      data_o    <= '0;
      user_o    <= '0;
      m3        <= '0;
    end else if (advance) begin
      out_valid <= v2;
      data_o    <= res_n;
      user_o    <= u2;
      m3        <= m2;
    end
  end

  logic edge_hit;
  assign edge_hit = out_valid & out_ready & (m3 == MODE_EDGE) & data_o[0];

  // Clear has priority, so a beat handed over in the clearing cycle is not counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      edge_count_o <= '0;
    end else if (clr_count_i) begin
      edge_count_o <= '0;
    end else if (edge_hit && (edge_count_o != {CNT_W{1'b1}})) begin
      edge_count_o <= edge_count_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Scoreboard bench for sobel_grad_pipe: reference model fills an expectation queue at input handshake.
module tb_sobel_grad_pipe;

  logic         clk;
  logic         reset;
  logic [215:0] win;
  logic [1:0]   usr;
  logic [1:0]   mode;
  logic [14:0]  thr;
  logic         in_valid;
  logic         in_ready;
  logic [28:0]  data_o;
  logic [1:0]   user_o;
  logic         out_valid;
  logic         out_ready;
  logic         clr;
  logic [23:0]  edge_count_o;

  sobel_grad_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .win_i        (win),
    .user_i       (usr),
    .mode_i       (mode),
    .thresh_i     (thr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_o       (data_o),
    .user_o       (user_o),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .clr_count_i  (clr),
    .edge_count_o (edge_count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [28:0] d;
    logic [1:0]  u;
    logic [1:0]  m;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cnt_m   = 0;
  bit   prev_stall = 1'b0;
  logic [28:0] prev_d;
  logic [1:0]  prev_u;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [28:0] model(input logic [215:0] w, input logic [1:0] m,
                                        input logic [14:0] th);
    int y[9];
    int gx, gy, ax, ay;
    for (int k = 0; k < 9; k++) begin
      y[k] = 5*int'(w[k*24+16 +: 8]) + 9*int'(w[k*24+8 +: 8]) + 2*int'(w[k*24 +: 8]);
    end
    gx = (y[2] + 2*y[5] + y[8]) - (y[0] + 2*y[3] + y[6]);
    gy = (y[6] + 2*y[7] + y[8]) - (y[0] + 2*y[1] + y[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (m)
      2'd0:    return 29'(gx*gx + gy*gy);
      2'd1:    return 29'(ax + ay);
      2'd2:    return ((ax + ay) >= int'(th)) ? 29'd1 : 29'd0;
      default: return 29'(gx*gx);
    endcase
  endfunction

  function automatic logic [215:0] cols(input logic [23:0] c0, input logic [23:0] c1,
                                        input logic [23:0] c2);
    logic [215:0] w;
    for (int r = 0; r < 3; r++) begin
      w[(3*r+0)*24 +: 24] = c0;
      w[(3*r+1)*24 +: 24] = c1;
      w[(3*r+2)*24 +: 24] = c2;
    end
    return w;
  endfunction

  function automatic logic [215:0] rows(input logic [23:0] r0, input logic [23:0] r1,
                                        input logic [23:0] r2);
    logic [215:0] w;
    for (int c = 0; c < 3; c++) begin
      w[(0+c)*24 +: 24] = r0;
      w[(3+c)*24 +: 24] = r1;
      w[(6+c)*24 +: 24] = r2;
    end
    return w;
  endfunction

  function automatic logic [215:0] rand_win();
    logic [215:0] w;
    for (int k = 0; k < 9; k++) w[k*24 +: 24] = 24'($urandom);
    return w;
  endfunction

  // Monitor: handshakes are stable at the falling edge and take effect at the next rising edge.
  always @(negedge clk) begin
    bit   hit;
    exp_t e;
    if (!reset) begin
      q.delete();
      cnt_m      = 0;
      prev_stall = 1'b0;
    end else begin
      check("edge_count", edge_count_o, cnt_m);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", data_o, prev_d);
        check("hold_user", user_o, prev_u);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      hit = 1'b0;
      if (out_valid && out_ready) begin
        check("q_nonempty", (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("data", data_o, e.d);
          check("user", user_o, e.u);
          hit = (e.m == 2'd2) && (e.d == 29'd1);
        end
      end
      if (clr) cnt_m = 0;
      else if (hit && cnt_m != 24'hFFFFFF) cnt_m++;
      if (in_valid && in_ready) begin
        e.d = model(win, mode, thr);
        e.u = usr;
        e.m = mode;
        q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = data_o;
      prev_u     = user_o;
    end
  end

  // All driving tasks start and end just after a rising edge.
  task automatic send(input logic [215:0] w, input logic [1:0] u, input logic [1:0] m,
                      input logic [14:0] t);
    bit acc;
    int n;
    win = w; usr = u; mode = m; thr = t;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic lat_beat(input logic [215:0] w, input logic [1:0] u, input logic [1:0] m);
    int n;
    send(w, u, m, 15'd0);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 3);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [215:0] edge_w, mirr_w, vert_w, flat_w;
    int k;
    int stale;
    bit rnd_done;

    edge_w = cols(24'h000000, 24'h3A7C11, 24'hFFFFFF);
    mirr_w = cols(24'hFFFFFF, 24'h808080, 24'h000000);
    vert_w = rows(24'h000000, 24'h55AA33, 24'hFFFFFF);
    flat_w = cols(24'h808080, 24'h808080, 24'h808080);

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    win = '0; usr = '0; mode = '0; thr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data", data_o, 0);
    check("rst_user", user_o, 0);
    check("rst_count", edge_count_o, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    lat_beat(flat_w, 2'b10, 2'd0);

    send(edge_w, 2'b01, 2'd0, 15'd0);
    send(edge_w, 2'b10, 2'd1, 15'd0);
    send(mirr_w, 2'b11, 2'd3, 15'd0);
    send(mirr_w, 2'b00, 2'd1, 15'd0);
    send(vert_w, 2'b01, 2'd0, 15'd0);
    drain();

    send(edge_w, 2'b00, 2'd2, 15'd1000);
    drain();
    check("count_edge", edge_count_o, 1);
    send(flat_w, 2'b00, 2'd2, 15'd1000);
    drain();
    check("count_flat", edge_count_o, 1);
    send(edge_w, 2'b11, 2'd2, 15'd1000);
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("count_clear", edge_count_o, 0);
    drain();

    fork
      begin
        for (int i = 0; i < 6; i++) send(rand_win(), 2'(i), 2'($urandom_range(0, 3)), 15'd2000);
      end
      begin
        k = 0;
        while (!out_valid && k < 50) begin
          @(posedge clk);
          #1;
          k++;
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(rand_win(), 2'($urandom), 2'($urandom_range(0, 3)), 15'($urandom_range(0, 32767)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send(edge_w, 2'b01, 2'd0, 15'd0);
    send(mirr_w, 2'b10, 2'd1, 15'd0);
    send(vert_w, 2'b11, 2'd3, 15'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_data", data_o, 0);
    check("midrst_user", user_o, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("no_stale_output", stale, 0);
    lat_beat(edge_w, 2'b10, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
